// File: rtl/completion_egress_router.sv
// rtl/completion_egress_router.sv - pairs completion headers with payloads and queues them per subunit
// Header beats are detected by change against the previous beat; each pair lands in a cfg/mem/io FIFO.

module completion_egress_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   accept_o,
   output logic [$clog2(DEPTH):0] count_next_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             pop, wr;

   assign valid_o  = (count_q != '0);
   assign pop      = valid_o && ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
   assign accept_o = (count_q != CW'(DEPTH)) || pop;
   assign wr       = push_i && accept_o;
   assign rdata_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      count_d = count_q;
      if (wr && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!wr && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   assign count_next_o = count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end
endmodule

module completion_egress_router #(
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [95:0]          in_sorted_header,
   input  logic [31:0]          in_payload,
   input  logic [2:0]           in_link_destination,
   output logic                 next_ready,
   output logic                 cfg_valid,
   output logic                 mem_valid,
   output logic                 io_valid,
   input  logic                 cfg_ready,
   input  logic                 mem_ready,
   input  logic                 io_ready,
   output logic [95:0]          cfg_header,
   output logic [95:0]          mem_header,
   output logic [95:0]          io_header,
   output logic [31:0]          cfg_payload,
   output logic [31:0]          mem_payload,
   output logic [31:0]          io_payload,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic [CNT_WIDTH-1:0] error_count
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic {ST_IDLE, ST_WAIT_PAYLOAD} state_t;

   state_t               state_q, state_d;
   logic [98:0]          prev_q;
   logic [95:0]          hdr_q, hdr_d;
   logic [1:0]           dest_q, dest_d;
   logic                 next_ready_q, next_ready_d;
   logic [CNT_WIDTH-1:0] drop_q, drop_d, err_q, err_d;
   logic                 header_beat, target_full;
   logic [2:0]           push, accept, valid, ready;
   logic [2:0][CW-1:0]   count_next;
   logic [2:0][127:0]    head;
   logic [127:0]         wdata;

   // A held header matches prev after its first cycle, so it is consumed only once.
   assign header_beat = (state_q == ST_IDLE) && (in_link_destination != 3'd0) &&
                        ({in_link_destination, in_sorted_header} != prev_q);
   assign wdata = {hdr_q, in_payload};
   assign ready = {io_ready, mem_ready, cfg_ready};

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      dest_d      = dest_q;
      drop_d      = drop_q;
      err_d       = err_q;
      push        = '0;
      target_full = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (header_beat) begin
               if (!in_link_destination[2]) begin
                  hdr_d   = in_sorted_header;
                  dest_d  = in_link_destination[1:0];
                  state_d = ST_WAIT_PAYLOAD;
               end else if (err_q != {CNT_WIDTH{1'b1}}) begin
                  err_d = err_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_WAIT_PAYLOAD: begin
            case (dest_q)
               2'd1: begin push[0] = 1'b1; target_full = !accept[0]; end
               2'd2: begin push[1] = 1'b1; target_full = !accept[1]; end
               2'd3: begin push[2] = 1'b1; target_full = !accept[2]; end
               default: ;
            endcase
            if (target_full && (drop_q != {CNT_WIDTH{1'b1}})) begin
               drop_d = drop_q + CNT_WIDTH'(1);
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Two free slots per FIFO absorb a header sent while this flag is one cycle stale.
      next_ready_d = (state_d == ST_IDLE) &&
                     (count_next[0] <= CW'(DEPTH - 2)) &&
                     (count_next[1] <= CW'(DEPTH - 2)) &&
                     (count_next[2] <= CW'(DEPTH - 2));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prev_q       <= '0;
         hdr_q        <= '0;
         dest_q       <= '0;
         next_ready_q <= 1'b0;
         drop_q       <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= {in_link_destination, in_sorted_header};
         hdr_q        <= hdr_d;
         dest_q       <= dest_d;
         next_ready_q <= next_ready_d;
         drop_q       <= drop_d;
         err_q        <= err_d;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_fifo
      completion_egress_fifo #(.DEPTH(DEPTH), .WIDTH(128)) u_fifo (
         .clk          (clk),
         .rst          (rst),
         .push_i       (push[g]),
         .wdata_i      (wdata),
         .ready_i      (ready[g]),
         .valid_o      (valid[g]),
         .rdata_o      (head[g]),
         .accept_o     (accept[g]),
         .count_next_o (count_next[g])
      );
   end

   assign next_ready  = next_ready_q;
   assign drop_count  = drop_q;
   assign error_count = err_q;
   assign cfg_valid   = valid[0];
   assign mem_valid   = valid[1];
   assign io_valid    = valid[2];
   assign cfg_header  = head[0][127:32];
   assign mem_header  = head[1][127:32];
   assign io_header   = head[2][127:32];
   assign cfg_payload = head[0][31:0];
   assign mem_payload = head[1][31:0];
   assign io_payload  = head[2][31:0];
endmodule

// File: tb/tb_completion_egress_router.sv
// tb/tb_completion_egress_router.sv - directed vector bench for completion_egress_router
// Table of single transactions plus hand-written fill/drain, saturation and reset sequences.

module tb_completion_egress_router;
   logic        clk = 1'b0;
   logic        rst;
   logic [95:0] in_sorted_header;
   logic [31:0] in_payload;
   logic [2:0]  in_link_destination;
   logic        next_ready;
   logic        cfg_valid, mem_valid, io_valid;
   logic        cfg_ready, mem_ready, io_ready;
   logic [95:0] cfg_header, mem_header, io_header;
   logic [31:0] cfg_payload, mem_payload, io_payload;
   logic [7:0]  drop_count, error_count;

   int tests = 0;
   int fails = 0;
   int exp_err = 0;
   int exp_drop = 0;

   typedef struct {
      logic [2:0]  dest;
      logic [95:0] hdr;
      logic [31:0] pay;
      logic [2:0]  exp_v;   // {io, mem, cfg}
   } vec_t;

   vec_t vecs [6];
   logic [95:0] mh [5];
   logic [95:0] ih [5];

   completion_egress_router #(.DEPTH(4), .CNT_WIDTH(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_sorted_header    (in_sorted_header),
      .in_payload          (in_payload),
      .in_link_destination (in_link_destination),
      .next_ready          (next_ready),
      .cfg_valid           (cfg_valid),
      .mem_valid           (mem_valid),
      .io_valid            (io_valid),
      .cfg_ready           (cfg_ready),
      .mem_ready           (mem_ready),
      .io_ready            (io_ready),
      .cfg_header          (cfg_header),
      .mem_header          (mem_header),
      .io_header           (io_header),
      .cfg_payload         (cfg_payload),
      .mem_payload         (mem_payload),
      .io_payload          (io_payload),
      .drop_count          (drop_count),
      .error_count         (error_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Header in cycle N, payload in cycle N+1; returns at cycle N+2.
   task automatic send_hdr(input logic [2:0] dest, input logic [95:0] hdr, input logic [31:0] pay);
      in_link_destination = dest;
      in_sorted_header    = hdr;
      tick();
      in_link_destination = 3'd0;
      in_sorted_header    = '0;
      in_payload          = pay;
      tick();
      in_payload          = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valids"}, {io_valid, mem_valid, cfg_valid}, 3'b000);
      check({tag, " headers"}, {cfg_header | mem_header | io_header}, 96'h0);
      check({tag, " payloads"}, {cfg_payload | mem_payload | io_payload}, 32'h0);
      check({tag, " drop_count"}, drop_count, 8'd0);
      check({tag, " error_count"}, error_count, 8'd0);
      check({tag, " next_ready"}, next_ready, 1'b0);
   endtask

   initial begin
      vecs[0] = '{3'd1, 96'h0123_4567_89AB_CDEF_0000_00A5, 32'hDEADBEEF, 3'b001};
      vecs[1] = '{3'd2, 96'h1111_2222_3333_4444_5555_6666, 32'h1234_5678, 3'b010};
      vecs[2] = '{3'd3, 96'hFFFF_0000_FFFF_0000_FFFF_0000, 32'hCAFE_F00D, 3'b100};
      vecs[3] = '{3'd5, 96'h0000_0000_0000_0000_0000_0055, 32'h0BAD_0BAD, 3'b000};
      vecs[4] = '{3'd7, 96'h0000_0000_0000_0000_0000_0077, 32'h0BAD_0077, 3'b000};
      vecs[5] = '{3'd1, 96'hABCD_0000_0000_0000_0000_0001, 32'h0000_0001, 3'b001};
      for (int i = 0; i < 5; i++) begin
         mh[i] = 96'h0000_00AA_0000_0000_0000_0000 + 96'(i);
         ih[i] = 96'h0000_00CC_0000_0000_0000_0000 + 96'(i);
      end

      rst = 1'b1;
      in_sorted_header = '0;
      in_payload = '0;
      in_link_destination = 3'd0;
      cfg_ready = 1'b0;
      mem_ready = 1'b0;
      io_ready = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check("post-reset next_ready", next_ready, 1'b1);

      for (int i = 0; i < 6; i++) begin
         send_hdr(vecs[i].dest, vecs[i].hdr, vecs[i].pay);
         if (vecs[i].exp_v == 3'b000) exp_err++;
         check($sformatf("vec%0d valids", i), {io_valid, mem_valid, cfg_valid}, vecs[i].exp_v);
         case (vecs[i].exp_v)
            3'b001: begin
               check($sformatf("vec%0d cfg_header", i), cfg_header, vecs[i].hdr);
               check($sformatf("vec%0d cfg_payload", i), cfg_payload, vecs[i].pay);
            end
            3'b010: begin
               check($sformatf("vec%0d mem_header", i), mem_header, vecs[i].hdr);
               check($sformatf("vec%0d mem_payload", i), mem_payload, vecs[i].pay);
            end
            3'b100: begin
               check($sformatf("vec%0d io_header", i), io_header, vecs[i].hdr);
               check($sformatf("vec%0d io_payload", i), io_payload, vecs[i].pay);
            end
            default: ;
         endcase
         check($sformatf("vec%0d error_count", i), error_count, 8'(exp_err));
         check($sformatf("vec%0d drop_count", i), drop_count, 8'd0);
         check($sformatf("vec%0d next_ready", i), next_ready, 1'b1);
         {io_ready, mem_ready, cfg_ready} = vecs[i].exp_v;
         tick();
         {io_ready, mem_ready, cfg_ready} = 3'b000;
         check($sformatf("vec%0d drained", i), {io_valid, mem_valid, cfg_valid}, 3'b000);
      end

      // Stable mem header held three cycles is taken once.
      in_link_destination = 3'd2;
      in_sorted_header = 96'h0000_0000_0000_0000_BEEF_0002;
      in_payload = 32'h5555_AAAA;
      tick();
      tick();
      tick();
      in_link_destination = 3'd0;
      in_sorted_header = '0;
      in_payload = '0;
      check("held mem_valid", mem_valid, 1'b1);
      check("held mem_header", mem_header, 96'h0000_0000_0000_0000_BEEF_0002);
      check("held mem_payload", mem_payload, 32'h5555_AAAA);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      check("held no duplicate", {io_valid, mem_valid, cfg_valid}, 3'b000);
      check("held error_count", error_count, 8'(exp_err));
      check("held drop_count", drop_count, 8'd0);

      // Fill mem FIFO, overflow by one, then drain in order.
      for (int i = 0; i < 5; i++) begin
         send_hdr(3'd2, mh[i], 32'hA000_0000 + 32'(i));
         if (i == 1) check("fill2 next_ready", next_ready, 1'b1);
         if (i == 2) check("fill3 next_ready", next_ready, 1'b0);
         if (i == 3) check("fill4 drop_count", drop_count, 8'd0);
      end
      exp_drop = 1;
      check("overflow drop_count", drop_count, 8'(exp_drop));
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d mem_valid", i), mem_valid, 1'b1);
         check($sformatf("drain%0d mem_header", i), mem_header, mh[i]);
         check($sformatf("drain%0d mem_payload", i), mem_payload, 32'hA000_0000 + 32'(i));
         tick();
      end
      mem_ready = 1'b0;
      check("drained mem_valid", mem_valid, 1'b0);
      check("drained mem_header zero", mem_header, 96'h0);
      check("drained next_ready", next_ready, 1'b1);

      // Illegal destinations and saturation.
      send_hdr(3'd5, 96'h0000_0000_0000_0000_0000_0099, 32'h0);
      exp_err++;
      check("dest5 error_count", error_count, 8'(exp_err));
      check("dest5 no push", {io_valid, mem_valid, cfg_valid}, 3'b000);
      for (int i = 0; i < 300; i++) begin
         in_link_destination = 3'd5;
         in_sorted_header = 96'h0000_0000_0000_0000_0001_0000 + 96'(i);
         tick();
      end
      in_link_destination = 3'd0;
      in_sorted_header = '0;
      tick();
      check("error_count saturated", error_count, 8'd255);
      check("saturate no push", {io_valid, mem_valid, cfg_valid}, 3'b000);
      check("saturate drop_count", drop_count, 8'(exp_drop));

      // Interleave with io stalled, then push+pop on a full io FIFO.
      cfg_ready = 1'b1;
      mem_ready = 1'b1;
      send_hdr(3'd1, 96'h0000_0000_0000_0000_0000_0C01, 32'hC0C0_0001);
      send_hdr(3'd3, ih[0], 32'hD000_0000);
      send_hdr(3'd2, 96'h0000_0000_0000_0000_0000_0A01, 32'hA0A0_0001);
      tick();
      check("interleave valids", {io_valid, mem_valid, cfg_valid}, 3'b100);
      check("interleave io_header", io_header, ih[0]);
      for (int i = 1; i < 4; i++) send_hdr(3'd3, ih[i], 32'hD000_0000 + 32'(i));
      in_link_destination = 3'd3;
      in_sorted_header = ih[4];
      tick();
      in_link_destination = 3'd0;
      in_sorted_header = '0;
      in_payload = 32'hD000_0004;
      io_ready = 1'b1;
      tick();
      io_ready = 1'b0;
      in_payload = '0;
      check("full push+pop drop_count", drop_count, 8'(exp_drop));
      io_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check($sformatf("io drain%0d header", i), io_header, ih[i]);
         check($sformatf("io drain%0d payload", i), io_payload, 32'hD000_0000 + 32'(i));
         tick();
      end
      io_ready = 1'b0;
      cfg_ready = 1'b0;
      mem_ready = 1'b0;
      check("io drained", io_valid, 1'b0);

      // Reset during the payload cycle drops the pending header.
      in_link_destination = 3'd1;
      in_sorted_header = 96'h0000_0000_0000_0000_0000_0F0F;
      tick();
      in_link_destination = 3'd0;
      in_sorted_header = '0;
      in_payload = 32'h1357_9BDF;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_payload = '0;
      check_all_zero("mid-reset");
      tick();
      check("mid-reset next_ready recovers", next_ready, 1'b1);
      check("mid-reset no push", {io_valid, mem_valid, cfg_valid}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
